// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock, start/busy/done handshake.
// Optional subtract mode (a - b - cin) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; sum/cout/ovf hold the last result
  // ADD   | one digit per edge, LSB digit first
  // DONE  | one-cycle done pulse; start here is accepted immediately

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
      $error("serial_adder: DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    opb;
  logic                carry;
  logic [CW-1:0]       cnt;

  logic [WIDTH-1:0]        b_eff;
  logic                    cin_eff;
  logic [DIGIT:0]          dsum;
  logic                    cmsb;
  logic [WIDTH+DIGIT-1:0]  acc_cat;
  logic [WIDTH-1:0]        acc_next;

  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_eff   = sub ? ~b : b;
    cin_eff = sub ? ~cin : cin;
`else
    b_eff   = b;
    cin_eff = cin;
`endif
  end

  // acc doubles as the result shift register: operand digits leave at the
  // bottom while sum digits enter at the top.
  always_comb begin
    dsum     = {1'b0, acc[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    cmsb     = acc[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1];
    acc_cat  = {dsum[DIGIT-1:0], acc};
    acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      acc   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            acc   <= a;
            opb   <= b_eff;
            carry <= cin_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ADD: begin
          acc   <= acc_next;
          opb   <= opb >> DIGIT;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum   <= acc_next;
            cout  <= dsum[DIGIT];
            ovf   <= cmsb ^ dsum[DIGIT];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
